// File: rtl/vfu_wr_inv_tracker_pkg.sv
// rtl/vfu_wr_inv_tracker_pkg.sv - shared types and line-span helper for the VFU write invalidation tracker
package vfu_wr_inv_tracker_pkg;

    localparam int VFU_ADDR_W           = 32;
    localparam int VFU_ID_W             = 6;
    localparam int VFU_LINE_BYTES       = 32;
    localparam int VFU_BURST_FIFO_DEPTH = 4;
    localparam int VFU_CNT_W            = 4;
    localparam int VFU_SPAN_W           = VFU_ADDR_W + 1;

    typedef enum logic [1:0] {
        VFU_BURST_FIXED = 2'b00,
        VFU_BURST_INCR  = 2'b01,
        VFU_BURST_WRAP  = 2'b10,
        VFU_BURST_RSVD  = 2'b11
    } vfu_burst_e;

    typedef enum logic {
        WALK_IDLE,
        WALK_ISSUE
    } vfu_walk_state_e;

    typedef struct packed {
        logic [VFU_ADDR_W-1:0] first_line;
        logic [VFU_ADDR_W-1:0] last_line;
    } vfu_line_span_t;

    // The end address is computed one bit wider so a burst running off the top
    // of the address space clamps to the highest line instead of wrapping to 0.
    function automatic vfu_line_span_t vfu_calc_span(
        input logic [VFU_ADDR_W-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [VFU_ADDR_W-1:0] line_mask
    );
        logic [15:0]           bytes;
        logic [15:0]           beat;
        logic [VFU_ADDR_W-1:0] start;
        logic [VFU_SPAN_W-1:0] end_x;
        vfu_line_span_t        span;
        bytes = (16'(len) + 16'd1) << size;
        beat  = 16'd1 << size;
        start = addr;
        end_x = {1'b0, addr} + VFU_SPAN_W'(bytes) - VFU_SPAN_W'(1);
        case (vfu_burst_e'(burst))
            VFU_BURST_FIXED: end_x = {1'b0, addr} + VFU_SPAN_W'(beat) - VFU_SPAN_W'(1);
            VFU_BURST_WRAP: begin
                start = addr & ~VFU_ADDR_W'(bytes - 16'd1);
                end_x = {1'b0, start} + VFU_SPAN_W'(bytes) - VFU_SPAN_W'(1);
            end
            default: ;
        endcase
        span.first_line = start & ~line_mask;
        span.last_line  = end_x[VFU_ADDR_W] ? ~line_mask
                                            : (end_x[VFU_ADDR_W-1:0] & ~line_mask);
        return span;
    endfunction

endpackage

// File: rtl/vfu_wr_inv_tracker_if.sv
// rtl/vfu_wr_inv_tracker_if.sv - AW/B snoop and invalidation handshake bundle
interface vfu_wr_inv_tracker_if #(
    parameter int ADDR_W = vfu_wr_inv_tracker_pkg::VFU_ADDR_W,
    parameter int ID_W   = vfu_wr_inv_tracker_pkg::VFU_ID_W
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              m_awvalid;
    logic              m_awready;
    logic              m_bvalid;
    logic              m_bready;
    logic [ID_W-1:0]   m_bid;
    logic [1:0]        m_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              inv_valid;
    logic [ADDR_W-1:0] inv_addr;
    logic              inv_ack;

    modport slave (
        input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  m_awready, m_bvalid, m_bid, m_bresp, s_bready, inv_ack,
        output s_awready, m_awvalid, m_bready, s_bvalid, s_bid, s_bresp,
        output inv_valid, inv_addr
    );

    modport master (
        output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output m_awready, m_bvalid, m_bid, m_bresp, s_bready, inv_ack,
        input  s_awready, m_awvalid, m_bready, s_bvalid, s_bid, s_bresp,
        input  inv_valid, inv_addr
    );
endinterface

// File: rtl/vfu_wr_inv_tracker_span_fifo.sv
// rtl/vfu_wr_inv_tracker_span_fifo.sv - sync FIFO of line spans with async reset
module vfu_wr_inv_tracker_span_fifo
    import vfu_wr_inv_tracker_pkg::*;
#(
    parameter int DEPTH = VFU_BURST_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  vfu_line_span_t push_data_i,
    input  logic           pop_i,
    output vfu_line_span_t pop_data_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  COUNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    vfu_line_span_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == COUNT_FULL);
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot first, so a simultaneous push is legal when full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vfu_wr_inv_tracker.sv
// rtl/vfu_wr_inv_tracker.sv - per-line dcache invalidation for VFU write bursts, gating B until done
module vfu_wr_inv_tracker
    import vfu_wr_inv_tracker_pkg::*;
#(
    parameter int LINE_BYTES       = VFU_LINE_BYTES,
    parameter int BURST_FIFO_DEPTH = VFU_BURST_FIFO_DEPTH,
    parameter int CNT_W            = VFU_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    vfu_wr_inv_tracker_if.slave bus,
    output logic                busy
);
    localparam logic [VFU_ADDR_W-1:0] LINE_MASK = VFU_ADDR_W'(LINE_BYTES - 1);
    localparam logic [VFU_ADDR_W-1:0] LINE_STEP = VFU_ADDR_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0]      CRED_ONE  = CNT_W'(1);

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    vfu_line_span_t  push_span, head_span;

    vfu_walk_state_e state_q;
    logic [VFU_ADDR_W-1:0] cur_q, last_q;
    logic            inv_valid_q;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic            credit_avail, credit_sat, at_last, complete, b_hs;

    assign bus.m_awvalid = bus.s_awvalid & ~fifo_full;
    assign bus.s_awready = bus.m_awready & ~fifo_full;
    assign fifo_push     = bus.s_awvalid & bus.m_awready & ~fifo_full;
    assign push_span     = vfu_calc_span(bus.s_awaddr, bus.s_awlen, bus.s_awsize,
                                         bus.s_awburst, LINE_MASK);
    assign fifo_pop      = (state_q == WALK_IDLE) & ~fifo_empty;

    vfu_wr_inv_tracker_span_fifo #(
        .DEPTH(BURST_FIFO_DEPTH)
    ) u_span_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_data_i(push_span),
        .pop_i      (fifo_pop),
        .pop_data_o (head_span),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign credit_avail = (credits_q != '0);
    assign credit_sat   = &credits_q;
    assign at_last      = (cur_q == last_q);
    // A saturated counter cannot record another completion, so the walker waits.
    assign complete     = (state_q == WALK_ISSUE) & bus.inv_ack & at_last & ~credit_sat;
    assign b_hs         = bus.m_bvalid & bus.s_bready & credit_avail;

    always_comb begin
        credits_d = credits_q;
        if (complete && !b_hs) begin
            credits_d = credits_q + CRED_ONE;
        end else if (b_hs && !complete) begin
            credits_d = credits_q - CRED_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WALK_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            inv_valid_q <= 1'b0;
            credits_q   <= '0;
        end else begin
            credits_q <= credits_d;
            case (state_q)
                WALK_IDLE: begin
                    if (!fifo_empty) begin
                        cur_q       <= head_span.first_line;
                        last_q      <= head_span.last_line;
                        inv_valid_q <= 1'b1;
                        state_q     <= WALK_ISSUE;
                    end
                end
                WALK_ISSUE: begin
                    if (complete) begin
                        inv_valid_q <= 1'b0;
                        state_q     <= WALK_IDLE;
                    end else if (bus.inv_ack && !at_last) begin
                        cur_q <= cur_q + LINE_STEP;
                    end
                end
                default: state_q <= WALK_IDLE;
            endcase
        end
    end

    assign bus.inv_valid = inv_valid_q;
    assign bus.inv_addr  = cur_q;
    assign bus.s_bvalid  = bus.m_bvalid & credit_avail;
    assign bus.m_bready  = bus.s_bready & credit_avail;
    assign bus.s_bid     = bus.m_bid;
    assign bus.s_bresp   = bus.m_bresp;
    assign busy          = ~fifo_empty | (state_q != WALK_IDLE) | credit_avail;

endmodule

// File: tb/tb_vfu_wr_inv_tracker.sv
// tb/tb_vfu_wr_inv_tracker.sv - self-checking bench for vfu_wr_inv_tracker
module tb_vfu_wr_inv_tracker;

    localparam int LB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];

    vfu_wr_inv_tracker_if #(.ADDR_W(32), .ID_W(6)) bus();

    vfu_wr_inv_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: every byte in the span, expressed as 64-bit arithmetic, mapped to lines.
    task automatic model_push(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        longint unsigned nb, beat, lo, hi, ln;
        nb   = (longint'(len) + 1) << size;
        beat = 64'd1 << size;
        if (burst == 2'b00) begin
            lo = addr; hi = lo + beat - 1;
        end else if (burst == 2'b10) begin
            lo = addr - (addr % nb); hi = lo + nb - 1;
        end else begin
            lo = addr; hi = lo + nb - 1;
        end
        if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
        for (ln = (lo / LB) * LB; ln <= hi; ln += LB) exp_q.push_back(32'(ln));
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_addr.delete();
        obs_cyc.delete();
    endtask

    function automatic int seq_diff();
        int d = 0;
        if (obs_addr.size() != exp_q.size()) d++;
        for (int i = 0; i < obs_addr.size() && i < exp_q.size(); i++)
            if (obs_addr[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int max_wait, output bit ok);
        ok = 1'b0;
        bus.s_awvalid = 1'b1; bus.s_awaddr = a; bus.s_awlen = l;
        bus.s_awsize = s; bus.s_awburst = b; bus.m_awready = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            #1;
            if (bus.s_awready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_awvalid = 1'b0;
        if (ok) model_push(a, l, s, b);
    endtask

    task automatic collect_inv(input int n, input bit rand_ack, input int max_cyc);
        for (int c = 0; c < max_cyc && obs_addr.size() < n; c++) begin
            bus.inv_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.inv_valid && bus.inv_ack) begin
                obs_addr.push_back(bus.inv_addr);
                obs_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        bus.inv_ack = 1'b0;
    endtask

    task automatic consume_b(input int n, output int got);
        got = 0;
        bus.m_bvalid = 1'b1; bus.s_bready = 1'b1;
        for (int c = 0; c < 60 && got < n; c++) begin
            bus.m_bid = 6'($urandom); bus.m_bresp = 2'($urandom);
            #1;
            if (bus.s_bvalid && bus.m_bready) got++;
            @(posedge clk); #1;
        end
        bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
    endtask

    task automatic test_reset();
        bus.m_bvalid = 1'b1; bus.m_awready = 1'b1; bus.s_awvalid = 1'b1;
        #2;
        checks++; if (bus.inv_valid !== 1'b0) begin failures++; $display("FAIL reset_inv_valid: got %b want 0", bus.inv_valid); end
        checks++; if (bus.inv_addr !== 32'h0) begin failures++; $display("FAIL reset_inv_addr: got %h want 00000000", bus.inv_addr); end
        checks++; if (bus.s_bvalid !== 1'b0) begin failures++; $display("FAIL reset_s_bvalid: got %b want 0", bus.s_bvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.s_awready !== 1'b1 || bus.m_awvalid !== 1'b1) begin failures++;
            $display("FAIL reset_aw_pass: got awready=%b awvalid=%b want 1 1", bus.s_awready, bus.m_awvalid); end
        bus.m_bvalid = 1'b0; bus.s_awvalid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_incr_basic(input string tag);
        bit ok; int c0, lat, spread;
        clear_model();
        send_aw(32'h1000, 8'd15, 3'd3, 2'b01, 10, ok);
        c0 = cyc;
        checks++; if (!ok) begin failures++; $display("FAIL %s_aw_accept: got 0 want 1", tag); end
        checks++; if (bus.inv_valid !== 1'b0) begin failures++; $display("FAIL %s_latency_early: got %b want 0", tag, bus.inv_valid); end
        collect_inv(4, 1'b0, 30);
        checks++; if (seq_diff() != 0) begin failures++;
            $display("FAIL %s_lines: got %0d lines want %0d (%0d diffs)", tag, obs_addr.size(), exp_q.size(), seq_diff()); end
        lat    = (obs_cyc.size() > 0) ? obs_cyc[0] - c0 : -1;
        spread = (obs_cyc.size() == 4) ? obs_cyc[3] - obs_cyc[0] : -1;
        checks++; if (lat != 1 || spread != 3) begin failures++;
            $display("FAIL %s_timing: got latency=%0d spread=%0d want 1 3", tag, lat, spread); end
        checks++; if (bus.inv_valid !== 1'b0) begin failures++; $display("FAIL %s_inv_drop: got %b want 0", tag, bus.inv_valid); end
        bus.m_bid = 6'h15; bus.m_bresp = 2'b10; bus.m_bvalid = 1'b1; bus.s_bready = 1'b1;
        #1;
        checks++; if (bus.s_bvalid !== 1'b1 || bus.s_bid !== 6'h15 || bus.s_bresp !== 2'b10 || bus.m_bready !== 1'b1) begin failures++;
            $display("FAIL %s_b_fwd: got v=%b id=%h resp=%b rdy=%b want 1 15 10 1", tag, bus.s_bvalid, bus.s_bid, bus.s_bresp, bus.m_bready); end
        @(posedge clk); #1;
        checks++; if (bus.s_bvalid !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL %s_b_consumed: got s_bvalid=%b busy=%b want 0 0", tag, bus.s_bvalid, busy); end
        bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
    endtask

    task automatic test_incr_aligned();
        run_incr_basic("incr");
    endtask

    task automatic test_unaligned_b_hold();
        bit ok; int early;
        clear_model();
        bus.m_bvalid = 1'b1; bus.m_bid = 6'h2A; bus.m_bresp = 2'b00; bus.s_bready = 1'b1;
        send_aw(32'h101C, 8'd0, 3'd3, 2'b01, 10, ok);
        early = 0;
        for (int c = 0; c < 20 && obs_addr.size() < 2; c++) begin
            bus.inv_ack = 1'b1;
            #1;
            if (bus.s_bvalid) early++;
            if (bus.inv_valid) begin obs_addr.push_back(bus.inv_addr); obs_cyc.push_back(cyc); end
            @(posedge clk); #1;
        end
        bus.inv_ack = 1'b0;
        checks++; if (seq_diff() != 0) begin failures++;
            $display("FAIL unaligned_lines: got %0d lines want %0d", obs_addr.size(), exp_q.size()); end
        checks++; if (early != 0) begin failures++; $display("FAIL unaligned_b_early: got %0d cycles want 0", early); end
        #1;
        checks++; if (bus.s_bvalid !== 1'b1 || bus.s_bid !== 6'h2A) begin failures++;
            $display("FAIL unaligned_b_release: got v=%b id=%h want 1 2a", bus.s_bvalid, bus.s_bid); end
        @(posedge clk); #1;
        checks++; if (bus.s_bvalid !== 1'b0) begin failures++; $display("FAIL unaligned_b_once: got %b want 0", bus.s_bvalid); end
        bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
    endtask

    task automatic test_fixed_wrap();
        bit ok; int got;
        logic [31:0] a[2];
        logic [1:0]  b[2];
        a[0] = 32'h2008; b[0] = 2'b00;
        a[1] = 32'h3030; b[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            clear_model();
            send_aw(a[i], 8'd7, 3'd3, b[i], 10, ok);
            collect_inv(exp_q.size() + 1, 1'b1, 40);
            checks++; if (seq_diff() != 0) begin failures++;
                $display("FAIL burst%0d_lines: got %0d lines want %0d", b[i], obs_addr.size(), exp_q.size()); end
            consume_b(1, got);
            checks++; if (got != 1) begin failures++; $display("FAIL burst%0d_b: got %0d want 1", b[i], got); end
        end
    endtask

    task automatic test_full_back_to_back();
        int idx, blocked, bad_aw, got;
        logic [31:0] base[6];
        clear_model();
        bus.inv_ack = 1'b0; bus.m_awready = 1'b1;
        idx = 0; blocked = 0; bad_aw = 0;
        for (int i = 0; i < 6; i++) base[i] = 32'h4000 + 32'(i) * 32'h100;
        bus.s_awlen = 8'd15; bus.s_awsize = 3'd3; bus.s_awburst = 2'b01;
        for (int c = 0; c < 12; c++) begin
            bus.s_awvalid = (idx < 6); bus.s_awaddr = base[idx < 6 ? idx : 0];
            #1;
            if (bus.s_awvalid && bus.s_awready) begin
                if (bus.m_awvalid !== 1'b1) bad_aw++;
                model_push(base[idx], 8'd15, 3'd3, 2'b01); idx++;
            end else begin
                blocked++;
                if (bus.m_awvalid !== 1'b0) bad_aw++;
            end
            @(posedge clk); #1;
        end
        checks++; if (idx != 5 || blocked != 7) begin failures++;
            $display("FAIL full_accept: got accepted=%0d blocked=%0d want 5 7", idx, blocked); end
        checks++; if (bad_aw != 0) begin failures++; $display("FAIL full_m_awvalid: got %0d bad cycles want 0", bad_aw); end
        checks++; if (bus.inv_valid !== 1'b1 || bus.inv_addr !== 32'h4000) begin failures++;
            $display("FAIL full_stall: got v=%b addr=%h want 1 00004000", bus.inv_valid, bus.inv_addr); end
        for (int c = 0; c < 200 && obs_addr.size() < 24; c++) begin
            bus.inv_ack = 1'b1;
            bus.s_awvalid = (idx < 6); bus.s_awaddr = base[idx < 6 ? idx : 0];
            #1;
            if (bus.s_awvalid && bus.s_awready) begin model_push(base[idx], 8'd15, 3'd3, 2'b01); idx++; end
            if (bus.inv_valid) begin obs_addr.push_back(bus.inv_addr); obs_cyc.push_back(cyc); end
            @(posedge clk); #1;
        end
        bus.s_awvalid = 1'b0; bus.inv_ack = 1'b0;
        checks++; if (idx != 6) begin failures++; $display("FAIL full_sixth: got accepted=%0d want 6", idx); end
        checks++; if (seq_diff() != 0) begin failures++;
            $display("FAIL full_order: got %0d lines want %0d (%0d diffs)", obs_addr.size(), exp_q.size(), seq_diff()); end
        consume_b(6, got);
        checks++; if (got != 6 || busy !== 1'b0) begin failures++;
            $display("FAIL full_b: got %0d busy=%b want 6 0", got, busy); end
    endtask

    task automatic test_overflow();
        bit ok; int got;
        clear_model();
        send_aw(32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 10, ok);
        collect_inv(exp_q.size() + 1, 1'b0, 10);
        checks++; if (seq_diff() != 0 || obs_addr.size() == 0) begin failures++;
            $display("FAIL overflow_lines: got %0d lines first=%h want %0d", obs_addr.size(),
                     obs_addr.size() > 0 ? obs_addr[0] : 32'h0, exp_q.size()); end
        consume_b(1, got);
        checks++; if (got != 1) begin failures++; $display("FAIL overflow_b: got %0d want 1", got); end
    endtask

    task automatic test_random();
        bit ok; int k, got, naw;
        int wl[4];
        logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;
        for (int it = 0; it < 30; it++) begin
            clear_model();
            k = $urandom_range(1, 3); naw = 0;
            for (int j = 0; j < k; j++) begin
                a = $urandom; s = 3'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
                l = (b == 2'b10) ? 8'(wl[$urandom_range(0, 3)]) : 8'($urandom_range(0, 15));
                send_aw(a, l, s, b, 10, ok);
                if (ok) naw++;
            end
            checks++; if (naw != k) begin failures++; $display("FAIL rand%0d_aw: got %0d want %0d", it, naw, k); end
            collect_inv(exp_q.size(), 1'b1, 400);
            checks++; if (seq_diff() != 0) begin failures++;
                $display("FAIL rand%0d_lines: got %0d lines want %0d (%0d diffs)", it, obs_addr.size(), exp_q.size(), seq_diff()); end
            consume_b(k, got);
            checks++; if (got != k || busy !== 1'b0) begin failures++;
                $display("FAIL rand%0d_b: got %0d busy=%b want %0d 0", it, got, busy, k); end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clear_model();
        send_aw(32'h5000, 8'd0, 3'd0, 2'b01, 10, ok);
        collect_inv(1, 1'b0, 10);
        send_aw(32'h5040, 8'd0, 3'd0, 2'b01, 10, ok);
        collect_inv(2, 1'b0, 10);
        for (int i = 0; i < 4; i++) send_aw(32'h6000 + 32'(i) * 32'h80, 8'd15, 3'd3, 2'b01, 10, ok);
        bus.m_bvalid = 1'b1; bus.s_bready = 1'b0;
        #1;
        checks++; if (bus.inv_valid !== 1'b1 || bus.s_bvalid !== 1'b1 || busy !== 1'b1) begin failures++;
            $display("FAIL rstmid_pre: got v=%b bv=%b busy=%b want 1 1 1", bus.inv_valid, bus.s_bvalid, busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.inv_valid !== 1'b0 || bus.s_bvalid !== 1'b0 || busy !== 1'b0 || bus.inv_addr !== 32'h0) begin failures++;
            $display("FAIL rstmid_async: got v=%b bv=%b busy=%b addr=%h want 0 0 0 0", bus.inv_valid, bus.s_bvalid, busy, bus.inv_addr); end
        bus.m_bvalid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        run_incr_basic("after_rst");
    endtask

    initial begin
        bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
        bus.s_awburst = '0; bus.m_awready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bid = '0;
        bus.m_bresp = '0; bus.s_bready = 1'b0; bus.inv_ack = 1'b0;
        test_reset();
        test_incr_aligned();
        test_unaligned_b_hold();
        test_fixed_wrap();
        test_full_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
